// File: rtl/ysyx_25040109_mdu_if.sv
// Request/response bundle between the EXU (master) and the RV32M multiply/divide unit (slave).
// Both handshakes transfer on a rising edge where valid && ready; the sender keeps its payload stable until then.
interface ysyx_25040109_mdu_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output in_valid, funct3, rs1_data, rs2_data, rd_addr, flush, out_ready,
    input  in_ready, out_valid, result, rd_addr_out, busy, dbg_state
  );

  modport slave (
    input  in_valid, funct3, rs1_data, rs2_data, rd_addr, flush, out_ready,
    output in_ready, out_valid, result, rd_addr_out, busy, dbg_state
  );
endinterface

// File: rtl/ysyx_25040109_mdu.sv
// Iterative RV32M unit: 32-cycle shift-add multiply / restoring divide on operand magnitudes,
// with divide-by-zero and signed-overflow answered directly from the accept edge.
module ysyx_25040109_mdu (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25040109_mdu_if.slave        bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic [31:0] result_q;

  logic        a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;

  assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign a_neg    = a_signed && bus.rs1_data[31];
  assign b_neg    = b_signed && bus.rs2_data[31];
  assign a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
  assign b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
  // Remainder follows the dividend sign; quotient and product follow the sign product.
  assign neg_in   = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = bus.funct3[2] && (bus.rs2_data == 32'd0);
  assign div_ovf  = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                    (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);

  // acc_q holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [31:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] div_next;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] fin;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign rem_sh   = {acc_q[62:32], acc_q[31]};
  assign diff     = {acc_q[63], rem_sh} - {1'b0, b_q};
  assign div_next = diff[32] ? {rem_sh, acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
  assign step     = op_q[2] ? div_next : mul_next;
  assign prod_fix = neg_q ? -step : step;

  always_comb begin
    fin = 32'd0;
    case (op_q)
      3'b000:         fin = prod_fix[31:0];
      3'b001, 3'b010,
      3'b011:         fin = prod_fix[63:32];
      3'b100, 3'b101: fin = neg_q ? -step[31:0] : step[31:0];
      default:        fin = neg_q ? -step[63:32] : step[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.funct3;
            rd_q  <= bus.rd_addr;
            neg_q <= neg_in;
            b_q   <= b_mag;
            acc_q <= {32'd0, a_mag};
            cnt_q <= 5'd0;
            if (div_zero) begin
              result_q <= bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
              state_q  <= DONE;
            end else if (div_ovf) begin
              result_q <= bus.funct3[1] ? 32'd0 : 32'h8000_0000;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= fin;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.rd_addr_out = rd_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
// Self-checking bench for the RV32M unit: directed corner cases, randomized ops against an
// arithmetic reference model, output back-pressure, flush and mid-operation reset.
module tb_ysyx_25040109_mdu;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  ysyx_25040109_mdu_if bus ();

  ysyx_25040109_mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_lat_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at a falling edge with the unit idle; returns 1 time unit after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_addr  = 5'($urandom);
  endtask

  // Waits for the result, optionally stalls the consumer, then retires it; ends at a falling edge.
  task automatic complete(input int hold);
    int          cyc;
    logic [31:0] exp_r;
    logic [4:0]  exp_rd;
    @(negedge clk);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    exp_r  = exp_q.pop_front();
    exp_rd = exp_rd_q.pop_front();
    check("latency", 32'(cyc), 32'(exp_lat_q.pop_front()));
    check("result", bus.result, exp_r);
    check("rd_addr_out", 32'(bus.rd_addr_out), 32'(exp_rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.result, exp_r);
      check("hold_rd", 32'(bus.rd_addr_out), 32'(exp_rd));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    // Consumer takes the result while a new request is already waiting: it must not be accepted.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    check("done_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("retire_in_ready", 32'(bus.in_ready), 32'd1);
    check("retire_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    bus.out_ready = (hold == 0);
    exp_q.push_back(ref_result(f, a, b));
    exp_rd_q.push_back(rd);
    exp_lat_q.push_back(ref_latency(f, a, b));
    issue(f, a, b, rd);
    complete(hold);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          seen;
    logic [31:0] ra, rb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.rs1_data  = 32'd0;
    bus.rs2_data  = 32'd0;
    bus.rd_addr   = 5'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", 32'(bus.rd_addr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic and special cases
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
    check("mul_7_m3_literal", exp_q.size() == 0 ? bus.result : 32'hX, 32'hFFFF_FFEB);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    do_op(3'b101, 32'd100, 32'd7, 5'd7, 0);
    do_op(3'b111, 32'd100, 32'd7, 5'd8, 0);
    do_op(3'b100, 32'd5, 32'd0, 5'd9, 0);
    do_op(3'b110, 32'd5, 32'd0, 5'd10, 0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    do_op(3'b101, 32'd0, 32'd0, 5'd13, 0);
    do_op(3'b000, 32'd0, 32'd0, 5'd14, 0);
    do_op(3'b101, 32'h1234_5678, 32'h1234_5678, 5'd15, 0);
    // Consumer back-pressure for 10 cycles
    do_op(3'b001, 32'h8765_4321, 32'h0FED_CBA9, 5'd16, 10);

    // Randomized operations
    for (int n = 0; n < 16; n++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick_operand();
      do_op(3'($urandom), ra, rb, 5'($urandom), 0);
    end

    // Flush in CALC cycle 10, with a competing request in the same cycle
    bus.out_ready = 1'b1;
    issue(3'b100, 32'd1000, 32'd3, 5'd20);
    repeat (9) @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle", 32'(bus.dbg_state), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    do_op(3'b110, 32'hFFFF_FC18, 32'd7, 5'd21, 0);

    // Asynchronous reset in CALC cycle 20, then accept on the first edge after release
    issue(3'b011, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd22);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_rd", 32'(bus.rd_addr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b010, 32'hFFFF_FF00, 32'h0000_0100, 5'd23, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25040109_mdu.md
YSYX_25040109_MDU -- requirements
Module: ysyx_25040109_mdu

Interface
REQ-001 SHALL have no parameters; operand and result width fixed at 32 bits.
REQ-002 SHALL provide ports (name direction width meaning):
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 in_valid  in  1  request valid from EXU
 in_ready  out  1  unit can accept request
 funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
 rs1_data  in  32  operand A
 rs2_data  in  32  operand B
 rd_addr  in  5  destination register tag
 flush  in  1  abort in-flight op
 out_valid  out  1  result valid
 out_ready  in  1  consumer accepts result
 result  out  32  op result
 rd_addr_out  out  5  tag of result
 busy  out  1  state != IDLE
REQ-003 SHALL use one clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, DONE.
REQ-005 in_ready SHALL equal (state==IDLE); request accepted on rising edge where in_valid && in_ready.
REQ-006 On accept, SHALL latch funct3, rd_addr, operands; both inputs may change afterwards without effect.
REQ-007 Normal ops: IDLE->CALC on accept; CALC runs exactly 32 cycles (5-bit counter 0..31); counter==31 -> DONE.
REQ-008 Multiply: shift-add on operand magnitudes, 64-bit product; sign correction: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU/MUL unsigned magnitudes; MUL returns product[31:0], others product[63:32].
REQ-009 Divide: restoring radix-2, one quotient bit per CALC cycle on magnitudes; DIV quotient negated when operand signs differ; REM remainder takes dividend sign; DIVU/REMU unsigned.
REQ-010 Divide by zero (rs2==0, funct3[2]==1): SHALL skip CALC, go IDLE->DONE; DIV/DIVU result 32'hFFFFFFFF, REM/REMU result = rs1_data.
REQ-011 Signed overflow (DIV/REM, rs1==32'h80000000, rs2==32'hFFFFFFFF): SHALL skip CALC; DIV result 32'h80000000, REM result 0.
REQ-012 Latency: normal op out_valid first high 33 cycles after accept edge; special cases 1 cycle after.
REQ-013 out_valid SHALL equal (state==DONE); result and rd_addr_out stable while out_valid high.
REQ-014 DONE->IDLE on edge where out_ready high; out_valid held indefinitely while out_ready low.
REQ-015 No new request accepted in DONE cycle even if out_ready high (in_ready low); back-to-back throughput one op per 34 cycles minimum.
REQ-016 flush high SHALL force state IDLE on next edge from any state, discarding result; flush overrides out_ready and in_valid in that cycle (no accept).
REQ-017 Operands of value 0 or equal to each other SHALL still take full 32 cycles (no early exit).
REQ-018 busy SHALL equal !in_ready.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, counter 0, result 0, rd_addr_out 0, out_valid 0, in_ready 1, busy 0, regardless of clk.
REQ-020 Reset asserted mid-CALC SHALL abort op; first edge after rst_n release with in_valid high accepts new request normally.

Verification
REQ-021 MUL rs1=7, rs2=-3 (32'hFFFFFFFD), out_ready=1 -> out_valid 33 cycles after accept, result 32'hFFFFFFEB.
REQ-022 MULHU rs1=rs2=32'hFFFFFFFF -> result 32'hFFFFFFFE; MULH same operands -> 0; MULHSU rs1=-1, rs2=32'hFFFFFFFF -> 32'hFFFFFFFF.
REQ-023 DIV rs1=-7, rs2=2 -> result -3 (32'hFFFFFFFD); REM same -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-024 DIV rs1=5, rs2=0 -> out_valid 1 cycle after accept, result 32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000 / -1 -> 32'h80000000, REM -> 0.
REQ-025 out_ready held low 10 cycles after out_valid -> result/rd_addr_out constant, in_ready low; out_ready high -> IDLE next edge.
REQ-026 flush at CALC cycle 10, and rst_n pulse at CALC cycle 20 of separate op -> IDLE next edge/immediately, out_valid never asserted, next op result correct.
